// File: rtl/aemb2_wb_copy_if.sv
// Data-side Wishbone classic bus between the block-copy initiator and a RAM responder.
// Signal names are given from the initiator's point of view.
interface aemb2_wb_copy_if #(
    parameter int AW = 14
);
    logic          dwb_cyc_o;
    logic          dwb_stb_o;
    logic          dwb_wre_o;
    logic [3:0]    dwb_sel_o;
    logic [AW-3:0] dwb_adr_o;
    logic [31:0]   dwb_dat_o;
    logic [31:0]   dwb_dat_i;
    logic          dwb_ack_i;

    modport master (
        output dwb_cyc_o, dwb_stb_o, dwb_wre_o, dwb_sel_o, dwb_adr_o, dwb_dat_o,
        input  dwb_dat_i, dwb_ack_i
    );

    modport slave (
        input  dwb_cyc_o, dwb_stb_o, dwb_wre_o, dwb_sel_o, dwb_adr_o, dwb_dat_o,
        output dwb_dat_i, dwb_ack_i
    );
endinterface

// File: rtl/aemb2_wb_copy.sv
// Wishbone classic block-copy initiator: one read then one write per word, one
// transfer outstanding, with a per-phase ack timeout.
module aemb2_wb_copy #(
    parameter int AW = 14,
    parameter int CW = 10,
    parameter int TW = 8
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 cmd_stb_i,
    input  logic [AW-3:0]        cmd_src_i,
    input  logic [AW-3:0]        cmd_dst_i,
    input  logic [CW-1:0]        cmd_len_i,
    output logic                 cmd_busy_o,
    output logic                 cmd_done_o,
    output logic                 cmd_err_o,
    aemb2_wb_copy_if.master      dwb,
    output logic [2:0]           dbg_state_o
);
    // Bus handshake: a transfer completes on each cycle where stb_o and ack_i are
    // both high; stb_o is held with stable adr/dat/wre until that ack arrives.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int WA = AW - 2;
    // Leaving at count 2**TW-2 without ack gives exactly 2**TW-1 unacked bus cycles.
    localparam logic [TW-1:0] TMO_LAST = {{(TW-1){1'b1}}, 1'b0};

    state_t          r_state, w_state_nx;
    logic [WA-1:0]   r_src, w_src_nx;
    logic [WA-1:0]   r_dst, w_dst_nx;
    logic [CW-1:0]   r_rem, w_rem_nx;
    logic [31:0]     r_buf, w_buf_nx;
    logic [TW-1:0]   r_tmo, w_tmo_nx;

    logic            w_cyc_nx;
    logic            w_wre_nx;
    logic [WA-1:0]   w_adr_nx;
    logic [31:0]     w_dat_nx;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_buf   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_src   <= w_src_nx;
            r_dst   <= w_dst_nx;
            r_rem   <= w_rem_nx;
            r_buf   <= w_buf_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_dst_nx   = r_dst;
        w_rem_nx   = r_rem;
        w_buf_nx   = r_buf;
        w_tmo_nx   = r_tmo;
        case (r_state)
            S_IDLE: begin
                if (cmd_stb_i) begin
                    w_src_nx   = cmd_src_i;
                    w_dst_nx   = cmd_dst_i;
                    w_rem_nx   = cmd_len_i;
                    w_tmo_nx   = '0;
                    w_state_nx = (cmd_len_i != '0) ? S_RD : S_DONE;
                end
            end
            S_RD: begin
                if (dwb.dwb_ack_i) begin
                    w_buf_nx   = dwb.dwb_dat_i;
                    w_tmo_nx   = '0;
                    w_state_nx = S_WR;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nx = S_ERR;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
            end
            S_WR: begin
                if (dwb.dwb_ack_i) begin
                    w_src_nx   = r_src + 1'b1;
                    w_dst_nx   = r_dst + 1'b1;
                    w_rem_nx   = r_rem - 1'b1;
                    w_tmo_nx   = '0;
                    w_state_nx = (r_rem == CW'(1)) ? S_DONE : S_RD;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nx = S_ERR;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            S_ERR:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines are
    // valid in the same cycle the state register enters RD/WR.
    always_comb begin
        w_cyc_nx = (w_state_nx == S_RD) || (w_state_nx == S_WR);
        w_wre_nx = (w_state_nx == S_WR);
        w_adr_nx = '0;
        w_dat_nx = '0;
        if (w_state_nx == S_RD) begin
            w_adr_nx = w_src_nx;
        end else if (w_state_nx == S_WR) begin
            w_adr_nx = w_dst_nx;
            w_dat_nx = w_buf_nx;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            dwb.dwb_cyc_o <= 1'b0;
            dwb.dwb_stb_o <= 1'b0;
            dwb.dwb_wre_o <= 1'b0;
            dwb.dwb_sel_o <= 4'h0;
            dwb.dwb_adr_o <= '0;
            dwb.dwb_dat_o <= '0;
            cmd_busy_o    <= 1'b0;
            cmd_done_o    <= 1'b0;
            cmd_err_o     <= 1'b0;
        end else begin
            dwb.dwb_cyc_o <= w_cyc_nx;
            dwb.dwb_stb_o <= w_cyc_nx;
            dwb.dwb_wre_o <= w_wre_nx;
            dwb.dwb_sel_o <= w_cyc_nx ? 4'hF : 4'h0;
            dwb.dwb_adr_o <= w_adr_nx;
            dwb.dwb_dat_o <= w_dat_nx;
            cmd_busy_o    <= (w_state_nx != S_IDLE);
            cmd_done_o    <= (w_state_nx == S_DONE);
            cmd_err_o     <= (w_state_nx == S_ERR);
        end
    end

    assign dbg_state_o = r_state;

endmodule
